// File: rtl/vc_chain_nre.sv
// Cascade of 4-bit counter digits with run-time code select (binary/BCD/Gray/Johnson).
// Define VC_CHAIN_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module vc_chain_nre #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  ce,
    input  logic                  R,
    input  logic                  L,
    input  logic                  up,
    input  logic [1:0]            mode,
    input  logic [4*DIGITS-1:0]   di,
    output logic [4*DIGITS-1:0]   Q,
    output logic [DIGITS-1:0]     TC,
    output logic                  CEO,
    output logic                  ovf
);

    localparam logic [1:0] MODE_BIN  = 2'b00;
    localparam logic [1:0] MODE_BCD  = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_JOHN = 2'b11;

    logic [4*DIGITS-1:0] q_r;
    logic [1:0]          mode_q_r;
    logic [4*DIGITS-1:0] q_nxt_s;
    logic [4*DIGITS-1:0] load_s;
    logic [DIGITS-1:0]   tc_s;
    logic [DIGITS-1:0]   en_s;
    logic                ceo_s;
    logic                mode_chg_s;

    function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic [3:0] bin_to_gray(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic logic johnson_legal(input logic [3:0] d);
        case (d)
            4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] step_digit(input logic [3:0] d, input logic [1:0] m, input logic u);
        case (m)
            MODE_BIN:  return u ? d + 4'd1 : d - 4'd1;
            MODE_BCD:  return u ? ((d >= 4'd9) ? 4'd0 : d + 4'd1)
                                : ((d == 4'd0) ? 4'd9 : d - 4'd1);
            MODE_GRAY: return bin_to_gray(u ? gray_to_bin(d) + 4'd1 : gray_to_bin(d) - 4'd1);
            MODE_JOHN: return u ? {d[2:0], ~d[3]} : {~d[0], d[3:1]};
            default:   return 4'd0;
        endcase
    endfunction

    function automatic logic is_terminal(input logic [3:0] d, input logic [1:0] m, input logic u);
        if (!u) begin
            return d == 4'h0;
        end else begin
            case (m)
                MODE_BIN:  return d == 4'hF;
                MODE_BCD:  return d == 4'h9;
                MODE_GRAY: return d == 4'h8;
                MODE_JOHN: return d == 4'h8;
                default:   return 1'b0;
            endcase
        end
    endfunction

    function automatic logic [3:0] legalise(input logic [3:0] d, input logic [1:0] m);
        case (m)
            MODE_BCD:  return (d > 4'd9) ? 4'd0 : d;
            MODE_JOHN: return johnson_legal(d) ? d : 4'd0;
            default:   return d;
        endcase
    endfunction

    // Per-digit terminal flags, ripple enables, stepped and load-legalised values
    always_comb begin
        logic carry;
        tc_s    = '0;
        en_s    = '0;
        q_nxt_s = q_r;
        load_s  = '0;
        carry   = ce;
        for (int k = 0; k < DIGITS; k++) begin
            tc_s[k]           = is_terminal(q_r[4*k +: 4], mode, up);
            en_s[k]           = carry;
            carry             = carry & tc_s[k];
            q_nxt_s[4*k +: 4] = en_s[k] ? step_digit(q_r[4*k +: 4], mode, up) : q_r[4*k +: 4];
            load_s[4*k +: 4]  = legalise(di[4*k +: 4], mode);
        end
        ceo_s = carry;
    end

    assign mode_chg_s = (mode != mode_q_r);

    // Counter state and sampled mode; a code switch flushes the digits so no illegal code survives
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_r      <= '0;
            mode_q_r <= 2'b00;
        end else begin
            mode_q_r <= mode;
            if (R) begin
                q_r <= '0;
            end else if (mode_chg_s) begin
                q_r <= '0;
            end else if (L) begin
                q_r <= load_s;
            end else begin
                q_r <= q_nxt_s;
            end
        end
    end

`ifdef VC_CHAIN_OVF_EN
    logic ovf_r;

    // Sticky overflow: any clearing event on the same edge beats a set
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ovf_r <= 1'b0;
        end else if (R || L || mode_chg_s) begin
            ovf_r <= 1'b0;
        end else if (ceo_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

    assign Q   = q_r;
    assign TC  = tc_s;
    assign CEO = ceo_s;

endmodule

// File: tb/tb_vc_chain_nre.sv
// Directed self-checking bench for vc_chain_nre with DIGITS=4.
module tb_vc_chain_nre;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        ce, R, L, up;
    logic [1:0]  mode;
    logic [15:0] di;
    logic [15:0] Q;
    logic [3:0]  TC;
    logic        CEO;
    logic        ovf;

    int vectors = 0;
    int errs    = 0;

`ifdef VC_CHAIN_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    vc_chain_nre #(.DIGITS(4)) dut (
        .clk(clk), .clr_n(clr_n), .ce(ce), .R(R), .L(L), .up(up),
        .mode(mode), .di(di), .Q(Q), .TC(TC), .CEO(CEO), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] jseq [8];
        logic [3:0] prev, g, i4;
        jseq = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

        clr_n = 1'b0; ce = 1'b0; R = 1'b0; L = 1'b0; up = 1'b1; mode = 2'b00; di = 16'h0;
        #12;
        check("reset_q", Q, 16'h0000);
        check("reset_tc", TC, 4'h0);
        check("reset_ceo", CEO, 1'b0);
        check("reset_ovf", ovf, 1'b0);
        clr_n = 1'b1;
        tick();

        // BCD chain wrap
        mode = 2'b01; tick();
        L = 1'b1; di = 16'h9998; tick(); L = 1'b0;
        check("bcd_load", Q, 16'h9998);
        ce = 1'b1; #1;
        check("bcd_ceo_first", CEO, 1'b0);
        tick();
        check("bcd_9999", Q, 16'h9999);
        check("bcd_tc_all", TC, 4'hF);
        check("bcd_ceo_second", CEO, 1'b1);
        tick(); ce = 1'b0; #1;
        check("bcd_wrap", Q, 16'h0000);
        check("bcd_ceo_after", CEO, 1'b0);
        check("bcd_ovf", ovf, OVF_ON);

        // BCD down wrap from zero
        up = 1'b0; ce = 1'b1; tick(); ce = 1'b0; up = 1'b1;
        check("bcd_down_wrap", Q, 16'h9999);

        // Load legalisation, then mode change with ce on the same edge
        L = 1'b1; di = 16'hA5F3; tick(); L = 1'b0;
        check("bcd_legalise", Q, 16'h0503);
        check("ovf_cleared_by_load", ovf, 1'b0);
        mode = 2'b10; ce = 1'b1; tick(); ce = 1'b0;
        check("mode_change_clear", Q, 16'h0000);

        // Gray sequence: one bit flips per step, TC at 1000
        for (int i = 1; i <= 16; i++) begin
            prev = Q[3:0];
            check("gray_tc", TC[0], prev == 4'h8);
            ce = 1'b1; tick(); ce = 1'b0;
            i4 = 4'(i);
            g  = i4 ^ (i4 >> 1);
            check("gray_onebit", $countones(prev ^ Q[3:0]), 1);
            check("gray_value", Q[3:0], g);
        end
        check("gray_carry", Q, 16'h0010);

        // Johnson full cycle
        mode = 2'b11; tick();
        for (int i = 0; i < 8; i++) begin
            check("john_value", Q[3:0], jseq[i]);
            check("john_tc", TC[0], i == 7);
            ce = 1'b1; tick(); ce = 1'b0;
        end
        check("john_return", Q, 16'h0010);
        up = 1'b0; #1;
        check("john_down_tc", TC, 4'b1101);
        ce = 1'b1; tick(); ce = 1'b0;
        check("john_down_step", Q, 16'h0008);

        // Binary borrow across the whole chain
        mode = 2'b00; tick();
        check("bin_clear", Q, 16'h0000);
        ce = 1'b1; #1;
        check("bin_borrow_ceo", CEO, 1'b1);
        check("bin_borrow_tc", TC, 4'hF);
        tick(); ce = 1'b0;
        check("bin_borrow", Q, 16'hFFFF);
        check("bin_ovf", ovf, OVF_ON);

        // Binary up carry
        up = 1'b1; L = 1'b1; di = 16'h00FF; tick(); L = 1'b0;
        check("bin_load", Q, 16'h00FF);
        ce = 1'b1; tick(); ce = 1'b0;
        check("bin_carry", Q, 16'h0100);

        // Mode change beats load
        mode = 2'b01; L = 1'b1; di = 16'h0777; tick(); L = 1'b0;
        check("mode_beats_load", Q, 16'h0000);
        mode = 2'b00; tick();

        // R beats L and ce
        L = 1'b1; di = 16'h1234; tick();
        R = 1'b1; di = 16'h5555; ce = 1'b1; tick(); R = 1'b0; L = 1'b0; ce = 1'b0;
        check("priority_r", Q, 16'h0000);

        // Asynchronous clear mid-count
        L = 1'b1; di = 16'h4321; tick(); L = 1'b0;
        ce = 1'b1; tick();
        check("count_before_clr", Q, 16'h4322);
        #2 clr_n = 1'b0; #1;
        check("async_clr", Q, 16'h0000);
        ce = 1'b0; clr_n = 1'b1; tick();
        check("after_clr", Q, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
